// File: rtl/and_gate.sv
// Bitwise AND unit for the ALU datapath: combinational result and zero/ones flags,
// plus an enable-gated registered copy of the result and its zero flag.
module and_gate #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   input  logic             en,
   output logic [WIDTH-1:0] y_q,
   output logic             zero,
   output logic             ones,
   output logic             zero_q
);

   assign y    = a & b;
   assign zero = ~|y;
   assign ones = &y;

   // Registered tap: reset wins over en, so a cleared result always reads as zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         y_q    <= '0;
         zero_q <= 1'b1;
      end else if (en) begin
         y_q    <= y;
         zero_q <= zero;
      end
   end

endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate: combinational AND and flags, registered path
// with reset/enable behaviour, and a 32-bit instance.
module tb_and_gate;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [2:0]  a, b;
   logic [2:0]  y, y_q;
   logic        zero, ones, zero_q;

   logic        en32;
   logic [31:0] a32, b32, y32, y_q32;
   logic        zero32, ones32, zero_q32;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   and_gate #(.WIDTH(3)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .y(y), .en(en),
      .y_q(y_q), .zero(zero), .ones(ones), .zero_q(zero_q)
   );

   and_gate #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .a(a32), .b(b32), .y(y32), .en(en32),
      .y_q(y_q32), .zero(zero32), .ones(ones32), .zero_q(zero_q32)
   );

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; en = 1'b1; a = 3'b111; b = 3'b111;
      for (int k = 0; k < 2; k++) begin
         edge_sample();
         checks++;
         if (y_q !== 3'b000) begin errors++; $display("FAIL reset_y_q edge%0d: got %b expected 000", k, y_q); end
         checks++;
         if (zero_q !== 1'b1) begin errors++; $display("FAIL reset_zero_q edge%0d: got %b expected 1", k, zero_q); end
         checks++;
         if (y !== 3'b111) begin errors++; $display("FAIL reset_y_comb edge%0d: got %b expected 111", k, y); end
      end
      @(negedge clk);
      reset = 1'b0;
      edge_sample();
      checks++;
      if (y_q !== 3'b111) begin errors++; $display("FAIL release_y_q: got %b expected 111", y_q); end
      checks++;
      if (zero_q !== 1'b0) begin errors++; $display("FAIL release_zero_q: got %b expected 0", zero_q); end
   endtask

   task automatic test_comb_basic();
      logic [2:0] va [7];
      logic [2:0] vb [7];
      logic [2:0] vy [7];
      logic       vz [7];
      logic       vo [7];
      va = '{3'b000, 3'b111, 3'b000, 3'b101, 3'b010, 3'b101, 3'b111};
      vb = '{3'b000, 3'b000, 3'b111, 3'b010, 3'b111, 3'b111, 3'b111};
      vy = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b101, 3'b111};
      vz = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b0,   1'b0,   1'b0};
      vo = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1};
      @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         a = va[i]; b = vb[i];
         #1;
         checks++;
         if (y !== vy[i]) begin errors++; $display("FAIL comb_y vec%0d: got %b expected %b", i, y, vy[i]); end
         checks++;
         if (zero !== vz[i]) begin errors++; $display("FAIL comb_zero vec%0d: got %b expected %b", i, zero, vz[i]); end
         checks++;
         if (ones !== vo[i]) begin errors++; $display("FAIL comb_ones vec%0d: got %b expected %b", i, ones, vo[i]); end
      end
   endtask

   task automatic test_sweep();
      logic [2:0] ea, eb, ey;
      en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            ea = i[2:0]; eb = j[2:0];
            ey = {ea[2] & eb[2], ea[1] & eb[1], ea[0] & eb[0]};
            a = ea; b = eb;
            #1;
            checks++;
            if (y !== ey || zero !== (ey == 3'd0) || ones !== (ey == 3'd7)) begin
               errors++;
               $display("FAIL sweep a=%b b=%b: got y=%b zero=%b ones=%b expected y=%b zero=%b ones=%b",
                        ea, eb, y, zero, ones, ey, (ey == 3'd0), (ey == 3'd7));
            end
         end
      end
   endtask

   task automatic test_load_hold();
      @(negedge clk);
      en = 1'b1; a = 3'b110; b = 3'b011;
      edge_sample();
      checks++;
      if (y_q !== 3'b010) begin errors++; $display("FAIL load_y_q: got %b expected 010", y_q); end
      checks++;
      if (zero_q !== 1'b0) begin errors++; $display("FAIL load_zero_q: got %b expected 0", zero_q); end
      @(negedge clk);
      en = 1'b0; a = 3'b111; b = 3'b111;
      for (int k = 0; k < 3; k++) begin
         edge_sample();
         checks++;
         if (y_q !== 3'b010) begin errors++; $display("FAIL hold_y_q edge%0d: got %b expected 010", k, y_q); end
         checks++;
         if (y !== 3'b111) begin errors++; $display("FAIL hold_y_comb edge%0d: got %b expected 111", k, y); end
      end
      // zero result loaded, then reset with en low still clears
      @(negedge clk);
      en = 1'b1; a = 3'b100; b = 3'b011;
      edge_sample();
      checks++;
      if (y_q !== 3'b000 || zero_q !== 1'b1) begin errors++; $display("FAIL load_zero: got y_q=%b zero_q=%b expected 000 1", y_q, zero_q); end
      @(negedge clk);
      a = 3'b111; b = 3'b111;
      edge_sample();
      @(negedge clk);
      reset = 1'b1; en = 1'b0;
      edge_sample();
      checks++;
      if (y_q !== 3'b000 || zero_q !== 1'b1) begin errors++; $display("FAIL midreset: got y_q=%b zero_q=%b expected 000 1", y_q, zero_q); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_wide();
      @(negedge clk);
      en32 = 1'b0;
      a32 = 32'hFFFF0000; b32 = 32'h0F0F0F0F;
      #1;
      checks++;
      if (y32 !== 32'h0F0F0000) begin errors++; $display("FAIL wide_y1: got %h expected 0f0f0000", y32); end
      checks++;
      if (zero32 !== 1'b0) begin errors++; $display("FAIL wide_zero1: got %b expected 0", zero32); end
      a32 = 32'hAAAAAAAA; b32 = 32'h55555555;
      #1;
      checks++;
      if (y32 !== 32'h0) begin errors++; $display("FAIL wide_y2: got %h expected 00000000", y32); end
      checks++;
      if (zero32 !== 1'b1) begin errors++; $display("FAIL wide_zero2: got %b expected 1", zero32); end
      a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF;
      #1;
      checks++;
      if (ones32 !== 1'b1) begin errors++; $display("FAIL wide_ones: got %b expected 1", ones32); end
      @(negedge clk);
      en32 = 1'b1; a32 = 32'h12345678; b32 = 32'hF0F0F0F0;
      edge_sample();
      checks++;
      if (y_q32 !== 32'h10305070) begin errors++; $display("FAIL wide_y_q: got %h expected 10305070", y_q32); end
      @(negedge clk);
      en32 = 1'b0;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; a = '0; b = '0;
      en32 = 1'b0; a32 = '0; b32 = '0;
      test_reset();
      test_comb_basic();
      test_sweep();
      test_load_hold();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/and_gate.md
Name: and_gate

Overview:
- Bitwise AND unit for the single-cycle ARM ALU datapath.
- Produces a combinational AND of two operand vectors, y = a & b, with zero latency.
- Also provides a registered copy of the result and zero/all-ones flags for ALU flag logic and pipelined debug taps.
- Width is parameterised; the default of 3 matches the ALU unit-test configuration.

Parameters:
- WIDTH, 3, operand and result width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y  output  WIDTH  combinational result, a & b.
- en  input  1  load enable for the registered result.
- y_q  output  WIDTH  registered result.
- zero  output  1  combinational flag, 1 when y == 0.
- ones  output  1  combinational flag, 1 when y is all ones.
- zero_q  output  1  registered copy of zero.

Interface decision:
- One clock; reset is synchronous and active-high (clk, reset).

Behaviour:
- y = a & b, bit by bit, for every bit position i in 0..WIDTH-1.
- y is purely combinational, with zero cycle latency. It settles within the same delta/timestep as any change on a or b, and no clock is needed.
- y is unaffected by reset, en and clk.
- zero = ~|y and ones = &y, both combinational.
- For WIDTH = 1: zero = ~y and ones = y.
- X/Z handling on a or b follows the standard 4-state AND rules:
  - 0 & X = 0.
  - 1 & X = X.
- y_q and zero_q register on the rising edge of clk:
  - If reset = 1: y_q <= 0 and zero_q <= 1. Reset overrides en.
  - Else if en = 1: y_q <= a & b and zero_q <= zero.
  - Else: hold the previous values.
- Reset values:
  - y_q = 0 and zero_q = 1.
  - y, zero and ones have no reset value; they always reflect the current inputs.
- Registered path latency is 1 cycle: a value presented before edge N is visible on y_q after edge N.
- Reset asserted mid-operation clears y_q on the next edge, regardless of en or the inputs. Deassertion takes effect on the first edge where reset = 0.
- Inputs changing between edges do not affect y_q until the next enabled edge.
- No internal state other than y_q and zero_q. No handshake.

Test Plan:
- a=000, b=000 -> y=000, zero=1, ones=0. Then a=111, b=000 -> y=000. Then a=000, b=111 -> y=000. Each check is made 1 time unit after applying the inputs, with clk idle.
- a=101, b=010 -> y=000, zero=1. a=010, b=111 -> y=010, zero=0. a=101, b=111 -> y=101. a=111, b=111 -> y=111, ones=1.
- Exhaustive sweep of all 64 (a, b) pairs at WIDTH=3 -> y == a & b, zero == (y==0), ones == (y==7) for every pair.
- reset=1 for 2 edges with en=1, a=b=111 -> y_q=000 and zero_q=1 while y=111. Release reset -> y_q=111 and zero_q=0 after the next edge.
- en=1, a=110, b=011, clock one edge -> y_q=010. Then en=0, a=b=111, clock 3 edges -> y_q stays 010 while y=111.
- WIDTH=32, a=0xFFFF0000, b=0x0F0F0F0F -> y=0x0F0F0000, zero=0. a=0xAAAAAAAA, b=0x55555555 -> y=0, zero=1.
